// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front end: the default pixel width,
// the pixel type and the index-width helper used to size the row/column counters.
package conv_pkg;

   localparam int WIDTH_BIT = 8;

   typedef logic [WIDTH_BIT-1:0] pixel_t;

   // Width of an index that ranges over n values, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of delay. Every enable shifts the row by one pixel, so dataOut
// is the pixel that was written exactly DEPTH enables earlier.
// Contents are not reset; stale data is never used to form a window.
module line_buffer #(
   parameter int DEPTH = 7,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             shiftEn,
   input  logic [WIDTH-1:0] dataIn,
   output logic [WIDTH-1:0] dataOut
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Shift register advancing only on accepted pixels.
   always_ff @(posedge clock) begin
      if (shiftEn) begin
         mem[0] <= dataIn;
         for (int k = 1; k < DEPTH; k++) begin
            mem[k] <= mem[k-1];
         end
      end
   end

   assign dataOut = mem[DEPTH-1];

endmodule

// File: rtl/window_stream_gen.sv
// Streaming sliding-window generator. Pixels arrive in raster order; SIZEKer-1
// line buffers supply the upper rows of each new window column, and a
// SIZEKer x SIZEKer register array shifts left once per accepted pixel.
// A window is flagged one cycle after the pixel that completes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready = !win_valid || win_ready, so a pixel can enter in the
// same cycle the current window leaves. While win_valid && !win_ready every
// win_* output holds and no pixel is accepted. Valid never depends on ready.
module window_stream_gen #(
   parameter int IMG_W     = 7,
   parameter int IMG_H     = 7,
   parameter int SIZEKer   = 3,
   parameter int STRIDE    = 1,
   parameter int WIDTH_BIT = conv_pkg::WIDTH_BIT
) (
   input  logic                                   clock,
   input  logic                                   nreset,
   input  logic [WIDTH_BIT-1:0]                   in_pixel,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic [SIZEKer*SIZEKer*WIDTH_BIT-1:0]   win_data,
   output logic [conv_pkg::idx_w(IMG_H)-1:0]      win_i,
   output logic [conv_pkg::idx_w(IMG_W)-1:0]      win_j,
   output logic                                   win_valid,
   input  logic                                   win_ready,
   output logic                                   win_last
);

   import conv_pkg::*;

   localparam int K  = SIZEKer;
   localparam int CW = idx_w(IMG_W);
   localparam int RW = idx_w(IMG_H);

   localparam logic [CW-1:0] COL_MAX    = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_FIRST  = CW'(K - 1);
   localparam logic [CW-1:0] COL_PRE    = CW'(K - 2);
   localparam logic [CW-1:0] COL_PH_MAX = CW'(STRIDE - 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(((IMG_W - K) / STRIDE) * STRIDE + K - 1);
   localparam logic [RW-1:0] ROW_MAX    = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_FIRST  = RW'(K - 1);
   localparam logic [RW-1:0] ROW_PRE    = RW'(K - 2);
   localparam logic [RW-1:0] ROW_PH_MAX = RW'(STRIDE - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(((IMG_H - K) / STRIDE) * STRIDE + K - 1);

   logic [CW-1:0]        col, colPh;
   logic [RW-1:0]        row, rowPh;
   logic                 accept, emit, isLast;
   logic [WIDTH_BIT-1:0] lbOut  [K-1];
   logic [WIDTH_BIT-1:0] newCol [K];
   logic [WIDTH_BIT-1:0] win    [K][K];

   assign in_ready = !win_valid || win_ready;
   assign accept   = in_valid && in_ready;

   // Line buffer chain: buffer 0 sees the incoming pixel, each later buffer
   // sees the row delayed by the one before it.
   for (genvar k = 0; k < K - 1; k++) begin : g_lb
      if (k == 0) begin : g_head
         line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH_BIT)) u_lb (
            .clock   (clock),
            .shiftEn (accept),
            .dataIn  (in_pixel),
            .dataOut (lbOut[k])
         );
      end else begin : g_tail
         line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH_BIT)) u_lb (
            .clock   (clock),
            .shiftEn (accept),
            .dataIn  (lbOut[k-1]),
            .dataOut (lbOut[k])
         );
      end
   end

   // New right-hand column, oldest row on top, current pixel at the bottom.
   always_comb begin
      for (int r = 0; r < K - 1; r++) begin
         newCol[r] = lbOut[K-2-r];
      end
      newCol[K-1] = in_pixel;
   end

   // Phase counters read zero on rows/columns that are a whole stride past the
   // first complete window, which replaces the modulo tests.
   assign emit   = (row >= ROW_FIRST) && (col >= COL_FIRST) &&
                   (rowPh == '0) && (colPh == '0);
   assign isLast = (row == ROW_LAST) && (col == COL_LAST);

   // Raster position and stride phase of the next pixel to be accepted.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         col   <= '0;
         row   <= '0;
         colPh <= '0;
         rowPh <= '0;
      end else if (accept) begin
         if (col == COL_MAX) begin
            col   <= '0;
            row   <= (row == ROW_MAX) ? '0 : row + 1'b1;
            rowPh <= (row == ROW_PRE || rowPh == ROW_PH_MAX) ? '0 : rowPh + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
         colPh <= (col == COL_PRE || colPh == COL_PH_MAX) ? '0 : colPh + 1'b1;
      end
   end

   // Window shift register and the registered window outputs.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win[r][c] <= '0;
            end
         end
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         win_i     <= '0;
         win_j     <= '0;
      end else begin
         if (accept) begin
            for (int r = 0; r < K; r++) begin
               for (int c = 0; c < K - 1; c++) begin
                  win[r][c] <= win[r][c+1];
               end
               win[r][K-1] <= newCol[r];
            end
         end
         if (accept && emit) begin
            win_valid <= 1'b1;
            win_last  <= isLast;
            win_i     <= row - ROW_FIRST;
            win_j     <= col - COL_FIRST;
         end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
         end
      end
   end

   for (genvar r = 0; r < K; r++) begin : g_row
      for (genvar c = 0; c < K; c++) begin : g_col
         assign win_data[(r*K+c)*WIDTH_BIT +: WIDTH_BIT] = win[r][c];
      end
   end

endmodule

// File: tb/tb_window_stream_gen.sv
// Bench for window_stream_gen: three instances (7x7 stride 1, 7x7 stride 2,
// 8x5 stride 1) fed from one directed sequence. Expected windows come from a
// frame-level model that cuts every window straight out of the image array.
module tb_window_stream_gen;

   localparam int KS  = 3;
   localparam int RECW = 1 + 3 + 3 + KS*KS*8;

   logic clock = 1'b0;
   logic nreset;

   logic [7:0]       inPixel  [3];
   logic             inValid  [3];
   logic             inReady  [3];
   logic [KS*KS*8-1:0] winData [3];
   logic [2:0]       winI     [3];
   logic [2:0]       winJ     [3];
   logic             winValid [3];
   logic             winReady [3];
   logic             winLast  [3];

   logic [RECW-1:0] expQ0[$], expQ1[$], expQ2[$];
   int  img [8][8];
   int  nVec = 0;
   int  nMis = 0;
   bit  bpArm = 1'b0;
   bit  rndReady = 1'b0;

   always #5 clock = ~clock;

   window_stream_gen #(.IMG_W(7), .IMG_H(7), .SIZEKer(3), .STRIDE(1), .WIDTH_BIT(8)) dutA (
      .clock(clock), .nreset(nreset), .in_pixel(inPixel[0]), .in_valid(inValid[0]),
      .in_ready(inReady[0]), .win_data(winData[0]), .win_i(winI[0]), .win_j(winJ[0]),
      .win_valid(winValid[0]), .win_ready(winReady[0]), .win_last(winLast[0]));

   window_stream_gen #(.IMG_W(7), .IMG_H(7), .SIZEKer(3), .STRIDE(2), .WIDTH_BIT(8)) dutB (
      .clock(clock), .nreset(nreset), .in_pixel(inPixel[1]), .in_valid(inValid[1]),
      .in_ready(inReady[1]), .win_data(winData[1]), .win_i(winI[1]), .win_j(winJ[1]),
      .win_valid(winValid[1]), .win_ready(winReady[1]), .win_last(winLast[1]));

   window_stream_gen #(.IMG_W(8), .IMG_H(5), .SIZEKer(3), .STRIDE(1), .WIDTH_BIT(8)) dutC (
      .clock(clock), .nreset(nreset), .in_pixel(inPixel[2]), .in_valid(inValid[2]),
      .in_ready(inReady[2]), .win_data(winData[2]), .win_i(winI[2]), .win_j(winJ[2]),
      .win_valid(winValid[2]), .win_ready(winReady[2]), .win_last(winLast[2]));

   task automatic check(input string tag, input logic [RECW-1:0] obs, input logic [RECW-1:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pushRec(input int d, input logic [RECW-1:0] rec);
      case (d)
         0:       expQ0.push_back(rec);
         1:       expQ1.push_back(rec);
         default: expQ2.push_back(rec);
      endcase
   endtask

   function automatic int qSize(input int d);
      case (d)
         0:       return expQ0.size();
         1:       return expQ1.size();
         default: return expQ2.size();
      endcase
   endfunction

   // Every window of a frame, in the order its completing pixel arrives.
   task automatic modelFrame(input int d, input int h, input int w, input int s);
      int lastI, lastJ;
      logic [KS*KS*8-1:0] data;
      lastI = ((h - KS) / s) * s;
      lastJ = ((w - KS) / s) * s;
      for (int i = 0; i <= h - KS; i += s) begin
         for (int j = 0; j <= w - KS; j += s) begin
            for (int r = 0; r < KS; r++)
               for (int c = 0; c < KS; c++)
                  data[(r*KS+c)*8 +: 8] = 8'(img[i+r][j+c]);
            pushRec(d, {(i == lastI && j == lastJ), 3'(i), 3'(j), data});
         end
      end
   endtask

   function automatic bit emits(input int r, input int c, input int s);
      return (r >= KS-1) && (c >= KS-1) && ((r-KS+1) % s == 0) && ((c-KS+1) % s == 0);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
      if (rndReady) winReady[0] = ($urandom_range(0, 3) != 0);
   endtask

   task automatic doBackpressure();
      logic [RECW-1:0] held;
      held = {winValid[0], winI[0], winJ[0], winData[0]};
      winReady[0] = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clock);
         check("bp_in_ready", inReady[0], 1'b0);
         check("bp_hold", {winValid[0], winI[0], winJ[0], winData[0]}, held);
         @(posedge clock);
         #1;
      end
      winReady[0] = 1'b1;
      bpArm = 1'b0;
   endtask

   task automatic pushPixel(input int d, input logic [7:0] px);
      bit acc;
      int n;
      inPixel[d] = px;
      inValid[d] = 1'b1;
      if (d == 0 && bpArm && winValid[0]) doBackpressure();
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
         @(negedge clock);
         acc = inReady[d];
         tick();
         n++;
      end
      check("accept", acc, 1'b1);
      inValid[d] = 1'b0;
   endtask

   task automatic streamFrame(input int d, input int h, input int w, input int s,
                              input bit sparse, input bit latChk);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            if (sparse)
               for (int g = 0; g < 20 && $urandom_range(0, 9) >= 3; g++) tick();
            pushPixel(d, 8'(img[r][c]));
            if (latChk) check($sformatf("latency_r%0d_c%0d", r, c), winValid[d], emits(r, c, s));
         end
      end
   endtask

   task automatic fillRamp(input int h, input int w);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            img[r][c] = r * w + c;
   endtask

   task automatic fillRandom(input int h, input int w);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            img[r][c] = int'($urandom_range(0, 255));
   endtask

   task automatic checkIdle(input int d);
      check("idle_valid", winValid[d], 1'b0);
      check("idle_last", winLast[d], 1'b0);
      check("idle_i", winI[d], 3'd0);
      check("idle_j", winJ[d], 3'd0);
      check("idle_data", winData[d], '0);
   endtask

   // Scoreboard: every consumed window must be the next one the model expects.
   always @(negedge clock) begin
      if (nreset) begin
         for (int d = 0; d < 3; d++) begin
            if (winValid[d] && winReady[d]) begin
               logic [RECW-1:0] got, exp;
               got = {winLast[d], winI[d], winJ[d], winData[d]};
               check("window_expected", qSize(d) > 0, 1'b1);
               if (qSize(d) > 0) begin
                  case (d)
                     0:       exp = expQ0.pop_front();
                     1:       exp = expQ1.pop_front();
                     default: exp = expQ2.pop_front();
                  endcase
                  check($sformatf("window_dut%0d", d), got, exp);
               end
            end
            if (!winValid[d]) check("last_without_valid", winLast[d], 1'b0);
         end
      end
   end

   initial begin
      nreset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         inPixel[d]  = '0;
         inValid[d]  = 1'b0;
         winReady[d] = 1'b0;
      end

      // Reset state: nothing valid, pixel input open.
      repeat (3) @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
         checkIdle(d);
         check("reset_in_ready", inReady[d], 1'b1);
      end
      nreset = 1'b1;
      for (int d = 0; d < 3; d++) winReady[d] = 1'b1;
      tick();
      for (int d = 0; d < 3; d++) checkIdle(d);

      // Basic 7x7 stride 1, with a 5-cycle stall on the first window.
      fillRamp(7, 7);
      modelFrame(0, 7, 7, 1);
      bpArm = 1'b1;
      streamFrame(0, 7, 7, 1, 1'b0, 1'b1);
      tick();
      check("basic_drained", expQ0.size(), 0);

      // Stride 2 on the same image.
      modelFrame(1, 7, 7, 2);
      streamFrame(1, 7, 7, 2, 1'b0, 1'b1);
      tick();
      check("stride_drained", expQ1.size(), 0);

      // Non-square 8x5, two frames back to back.
      fillRandom(5, 8);
      modelFrame(2, 5, 8, 1);
      streamFrame(2, 5, 8, 1, 1'b0, 1'b1);
      fillRandom(5, 8);
      modelFrame(2, 5, 8, 1);
      streamFrame(2, 5, 8, 1, 1'b0, 1'b1);
      tick();
      check("nonsquare_drained", expQ2.size(), 0);

      // Sparse input with random downstream stalls, ramp then random image.
      rndReady = 1'b1;
      fillRamp(7, 7);
      modelFrame(0, 7, 7, 1);
      streamFrame(0, 7, 7, 1, 1'b1, 1'b0);
      fillRandom(7, 7);
      modelFrame(0, 7, 7, 1);
      streamFrame(0, 7, 7, 1, 1'b1, 1'b0);
      rndReady = 1'b0;
      winReady[0] = 1'b1;
      for (int n = 0; n < 20 && expQ0.size() > 0; n++) tick();
      check("sparse_drained", expQ0.size(), 0);

      // Mid-frame reset after 20 pixels; the pending window is discarded.
      fillRamp(7, 7);
      modelFrame(0, 7, 7, 1);
      for (int p = 0; p < 20; p++) pushPixel(0, 8'(img[p / 7][p % 7]));
      check("pre_reset_valid", winValid[0], 1'b1);
      nreset = 1'b0;
      #1;
      expQ0.delete();
      checkIdle(0);
      tick();
      check("in_reset_valid", winValid[0], 1'b0);
      nreset = 1'b1;
      tick();
      checkIdle(0);
      modelFrame(0, 7, 7, 1);
      streamFrame(0, 7, 7, 1, 1'b0, 1'b1);

      for (int n = 0; n < 20 && (expQ0.size() + expQ1.size() + expQ2.size()) > 0; n++) tick();
      check("final_drain_a", expQ0.size(), 0);
      check("final_drain_b", expQ1.size(), 0);
      check("final_drain_c", expQ2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
